// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned WIDTH x WIDTH shift-and-add multiplier.
//   Each CALC cycle adds the multiplicand to the high half of the product
//   register (when P[0] is set), then shifts {carry, sum, low half} right by one.
//   Ports:
//     clk     - clock, rising edge
//     rst_n   - synchronous reset, active-low
//     start   - request; accepted only in IDLE or DONE
//     a, b    - multiplicand / multiplier, captured on accepted start
//     busy    - high while CALC
//     done    - one-cycle pulse when product becomes valid
//     product - 2*WIDTH-bit result, held until the next final step or reset
//   Optional feature: define MUL_EARLY_TERM_EN to skip CALC when an operand is zero.
// Also contains ripple_carry_adder, the W-bit adder cell used when WIDTH == 4.

// W-bit ripple-carry adder built from a chain of full adders.
module ripple_carry_adder #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];
endmodule

module shift_add_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]      p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PW-1:0]      product_q, product_d;

  logic               accept;
  logic               early_acc;
  logic               last_step;
  logic [WIDTH-1:0]   add_a, add_b, add_s;
  logic               add_c;
  logic [PW-1:0]      p_step;

  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_step = (state_q == CALC) && (cnt_q == CNT_W'(WIDTH - 1));

`ifdef MUL_EARLY_TERM_EN
  assign early_acc = accept && ((a == '0) || (b == '0));
`else
  assign early_acc = 1'b0;
`endif

  // Adder operands: high half of P plus the multiplicand gated by the current multiplier bit.
  assign add_a = p_q[PW-1:WIDTH];
  assign add_b = p_q[0] ? mcand_q : '0;

  if (WIDTH == 4) begin : g_rca
    ripple_carry_adder #(.W(WIDTH)) u_rca (
      .a    (add_a),
      .b    (add_b),
      .cin  (1'b0),
      .s    (add_s),
      .cout (add_c)
    );
  end else begin : g_add
    assign {add_c, add_s} = SUM_W'(add_a) + SUM_W'(add_b);
  end

  // Carry re-enters as the new MSB so no bit of the partial sum is dropped.
  assign p_step = {add_c, add_s, p_q[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; any unused encoding falls back to IDLE.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = early_acc ? DONE : CALC;
        else        state_d = IDLE;
      end
      CALC:       state_d = last_step ? DONE : CALC;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    mcand_d   = mcand_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = (state_d == CALC);
    done_d    = last_step || early_acc;

    if (accept) begin
      mcand_d = a;
      p_d     = {{WIDTH{1'b0}}, b};
      cnt_d   = '0;
      if (early_acc) product_d = '0;
    end else if (state_q == CALC) begin
      p_d   = p_step;
      cnt_d = cnt_q + CNT_W'(1);
      if (last_step) product_d = p_step;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      mcand_q   <= mcand_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
endmodule
